// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared widths, instruction field offsets and sequencer state encoding
package ctrl_pkg;
  localparam int DEF_REGFILE_ADDR_WIDTH = 2;
  localparam int DEF_DATA_ADDR_WIDTH = 4;
  function automatic int iw_width(input int ra, input int da);
    return 2 + 2 * ra + 4 * da;
  endfunction
  localparam int IW_DEF = iw_width(DEF_REGFILE_ADDR_WIDTH, DEF_DATA_ADDR_WIDTH);
  // Field LSB offsets at default widths, MSB to LSB
  localparam int LSTG_F_BIT = IW_DEF - 1;
  localparam int STARTUPS_F_BIT = IW_DEF - 2;
  localparam int RESULT_REG_LSB = STARTUPS_F_BIT - DEF_REGFILE_ADDR_WIDTH;
  localparam int ERROR_REG_LSB = RESULT_REG_LSB - DEF_REGFILE_ADDR_WIDTH;
  localparam int DATA_BPTR_LSB = ERROR_REG_LSB - DEF_DATA_ADDR_WIDTH;
  localparam int DATA_LPTR_LSB = DATA_BPTR_LSB - DEF_DATA_ADDR_WIDTH;
  localparam int DATA_HPTR_LSB = DATA_LPTR_LSB - DEF_DATA_ADDR_WIDTH;
  localparam int FILT_COEF_PTR_LSB = DATA_HPTR_LSB - DEF_DATA_ADDR_WIDTH;
  typedef enum logic [1:0] {EMPTY, LOAD, READY, RESP} state_t;
endpackage

// File: rtl/ctrl_iseq_mem.sv
// ctrl_iseq_mem: single-port synchronous RAM with registered read
module ctrl_iseq_mem #(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[addr] <= wdata;
  // Only the read register is reset; array contents survive reset
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= r_mem[addr];
endmodule

// File: rtl/ctrl_iseq.sv
// ctrl_iseq: instruction store and sequencer; loads a program then fetches one word per request
module ctrl_iseq #(
  parameter int REGFILE_ADDR_WIDTH = ctrl_pkg::DEF_REGFILE_ADDR_WIDTH,
  parameter int DATA_ADDR_WIDTH = ctrl_pkg::DEF_DATA_ADDR_WIDTH,
  parameter int PROG_SIZE = 32,
  localparam int IW = ctrl_pkg::iw_width(REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH),
  localparam int PA_W = $clog2(PROG_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          prog,
  input  logic          load_we,
  input  logic [IW-1:0] load_word,
  input  logic          ptr_req,
  output logic [IW-1:0] instr_word,
  output logic          iw_valid,
  output logic [PA_W-1:0] pc,
  output logic          prog_empty,
  output logic          prog_full,
  output logic          wrap,
  output logic          load_err
);
  import ctrl_pkg::*;
  localparam logic [PA_W:0] FULL = (PA_W + 1)'(PROG_SIZE);
  state_t r_state, w_next;
  logic [PA_W:0] r_wptr, r_len;
  logic [PA_W-1:0] r_pc;
  logic w_run, w_wfull, w_fetch, w_write, w_last;
  assign w_run = en & ~prog;
  assign w_wfull = r_wptr == FULL;
  assign w_fetch = w_run & ptr_req & (r_state == READY);
  assign w_write = en & prog & load_we & (r_state == LOAD) & ~w_wfull;
  // Fetched word is the RAM read register, so lstg_f is visible during RESP
  assign w_last = instr_word[IW-1] | ({1'b0, r_pc} == r_len - 1'b1);
  ctrl_iseq_mem #(.DEPTH(PROG_SIZE), .AW(PA_W), .W(IW)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(w_write),
    .re(w_fetch),
    .addr(r_state == LOAD ? r_wptr[PA_W-1:0] : r_pc),
    .wdata(load_word),
    .rdata(instr_word)
  );
  always_comb begin
    w_next = r_state;
    if (en && prog) w_next = LOAD;
    else if (en)
      w_next = r_state == LOAD  ? (r_wptr != '0 ? READY : EMPTY) :
               r_state == READY ? (ptr_req ? RESP : READY) :
               r_state == RESP  ? READY : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= EMPTY;
      r_wptr <= '0;
      r_pc <= '0;
      r_len <= '0;
    end else if (en) begin
      r_state <= w_next;
      if (prog && r_state != LOAD) begin
        r_wptr <= '0;
        r_pc <= '0;
        r_len <= '0;
      end else if (w_write) r_wptr <= r_wptr + 1'b1;
      else if (!prog && r_state == LOAD) r_len <= r_wptr;
      else if (!prog && r_state == RESP) r_pc <= w_last ? '0 : r_pc + 1'b1;
    end
  assign iw_valid = w_run & (r_state == RESP);
  assign wrap = iw_valid & w_last;
  assign load_err = en & ((prog & load_we & (r_state == LOAD) & w_wfull) |
                          (ptr_req & (r_state == EMPTY || r_state == LOAD)));
  assign prog_empty = (r_state == EMPTY) || (r_state == LOAD);
  assign prog_full = r_state == LOAD ? w_wfull : (r_len == FULL);
  assign pc = r_pc;
endmodule

// File: tb/tb_ctrl_iseq.sv
// tb_ctrl_iseq: scenario tasks with a scoreboard of expected fetched words
module tb_ctrl_iseq;
  logic clk = 1'b0;
  logic rst, en, prog, load_we, ptr_req;
  logic [21:0] load_word, instr_word;
  logic iw_valid, prog_empty, prog_full, wrap, load_err;
  logic [4:0] pc;
  typedef struct {logic [21:0] word; logic wrap;} exp_t;
  exp_t sb[$];
  logic [21:0] img[32];
  int n_cmp = 0, n_bad = 0;

  ctrl_iseq dut (
    .clk(clk), .rst(rst), .en(en), .prog(prog), .load_we(load_we),
    .load_word(load_word), .ptr_req(ptr_req), .instr_word(instr_word),
    .iw_valid(iw_valid), .pc(pc), .prog_empty(prog_empty),
    .prog_full(prog_full), .wrap(wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] word_of(input int i, input bit lstg);
    logic [20:0] body;
    body = 21'(i * 4099 + 77);
    return {lstg, body};
  endfunction

  task automatic load_prog(input int n, input int lstg_at);
    prog = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      img[i] = word_of(i, i == lstg_at);
      load_word = img[i];
      load_we = 1'b1;
      @(negedge clk);
    end
    load_we = 1'b0;
    prog = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fetch;
    exp_t e;
    ptr_req = 1'b1;
    #3;
    n_cmp++;
    if (iw_valid !== 1'b0) begin n_bad++; $display("FAIL req_cycle_valid: got %b want 0", iw_valid); end
    @(negedge clk);
    ptr_req = 1'b0;
    #3;
    n_cmp++;
    if (iw_valid !== 1'b1) begin n_bad++; $display("FAIL resp_valid: got %b want 1", iw_valid); end
    n_cmp++;
    if (sb.size() == 0) begin n_bad++; $display("FAIL scoreboard_empty: got 0 entries want 1"); end
    else begin
      e = sb.pop_front();
      n_cmp++;
      if (instr_word !== e.word) begin n_bad++; $display("FAIL fetch_word: got %h want %h", instr_word, e.word); end
      n_cmp++;
      if (wrap !== e.wrap) begin n_bad++; $display("FAIL fetch_wrap: got %b want %b", wrap, e.wrap); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; prog = 1'b0; load_we = 1'b0; ptr_req = 1'b0; load_word = '0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({pc, instr_word} !== 27'd0) begin n_bad++; $display("FAIL reset_regs: got pc=%h iw=%h want 0", pc, instr_word); end
    n_cmp++;
    if ({iw_valid, wrap, load_err, prog_empty, prog_full} !== 5'b00010) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00010", {iw_valid, wrap, load_err, prog_empty, prog_full});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_three_words;
    load_prog(3, 2);
    n_cmp++;
    if (prog_empty !== 1'b0) begin n_bad++; $display("FAIL three_not_empty: got %b want 0", prog_empty); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (pc !== 5'(k % 3)) begin n_bad++; $display("FAIL three_pc: got %0d want %0d", pc, k % 3); end
      sb.push_back('{img[k % 3], k == 2});
      do_fetch();
    end
  endtask

  task automatic test_five_words;
    load_prog(5, -1);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (pc !== 5'(k % 5)) begin n_bad++; $display("FAIL five_pc: got %0d want %0d", pc, k % 5); end
      sb.push_back('{img[k % 5], k == 4});
      do_fetch();
    end
  endtask

  task automatic test_overflow;
    prog = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 33; i++) begin
      if (i < 32) img[i] = word_of(i + 100, 1'b0);
      load_word = i < 32 ? img[i] : 22'h15a5a5;
      load_we = 1'b1;
      #3;
      if (i == 31) begin
        n_cmp++;
        if (prog_full !== 1'b0) begin n_bad++; $display("FAIL ovf_full_early: got %b want 0", prog_full); end
      end
      if (i == 32) begin
        n_cmp++;
        if (prog_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full: got %b want 1", prog_full); end
      end
      n_cmp++;
      if (load_err !== (i == 32)) begin n_bad++; $display("FAIL ovf_err[%0d]: got %b want %b", i, load_err, i == 32); end
      @(negedge clk);
    end
    load_we = 1'b0;
    prog = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (prog_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full_ready: got %b want 1", prog_full); end
    for (int k = 0; k < 32; k++) begin
      sb.push_back('{img[k], k == 31});
      do_fetch();
    end
  endtask

  task automatic test_empty_prog;
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    @(negedge clk);
    ptr_req = 1'b1;
    #3;
    n_cmp++;
    if ({prog_empty, load_err, iw_valid} !== 3'b110) begin
      n_bad++; $display("FAIL empty_req: got %b want 110", {prog_empty, load_err, iw_valid});
    end
    @(negedge clk);
    ptr_req = 1'b0;
    #3;
    n_cmp++;
    if ({prog_empty, iw_valid} !== 2'b10) begin n_bad++; $display("FAIL empty_after: got %b want 10", {prog_empty, iw_valid}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    exp_t e;
    load_prog(4, -1);
    for (int k = 0; k < 3; k++) sb.push_back('{img[k], 1'b0});
    ptr_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #3;
      if (iw_valid === 1'b1) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_cmp++;
          if (instr_word !== e.word) begin n_bad++; $display("FAIL b2b_word: got %h want %h", instr_word, e.word); end
        end
      end
      @(negedge clk);
    end
    ptr_req = 1'b0;
    n_cmp++;
    if (pulses != 3) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    n_cmp++;
    if (pc !== 5'd3) begin n_bad++; $display("FAIL b2b_pc: got %0d want 3", pc); end
    ptr_req = 1'b1;
    @(negedge clk);
    ptr_req = 1'b0;
    en = 1'b0;
    #3;
    n_cmp++;
    if (iw_valid !== 1'b0) begin n_bad++; $display("FAIL en_valid0: got %b want 0", iw_valid); end
    @(negedge clk);
    #3;
    n_cmp++;
    if ({pc, iw_valid} !== {5'd3, 1'b0}) begin n_bad++; $display("FAIL en_freeze: got pc=%0d v=%b want 3/0", pc, iw_valid); end
    @(negedge clk);
    en = 1'b1;
    #3;
    n_cmp++;
    if ({iw_valid, wrap} !== 2'b11 || instr_word !== img[3]) begin
      n_bad++; $display("FAIL en_resume: got v=%b w=%b iw=%h want 1/1/%h", iw_valid, wrap, instr_word, img[3]);
    end
    @(negedge clk);
    n_cmp++;
    if (pc !== 5'd0) begin n_bad++; $display("FAIL en_wrap_pc: got %0d want 0", pc); end
    en = 1'b0;
    ptr_req = 1'b1;
    @(negedge clk);
    en = 1'b1;
    ptr_req = 1'b0;
    #3;
    n_cmp++;
    if (iw_valid !== 1'b0) begin n_bad++; $display("FAIL lost_req: got %b want 0", iw_valid); end
    @(negedge clk);
  endtask

  task automatic test_abort_and_rst;
    ptr_req = 1'b1;
    @(negedge clk);
    ptr_req = 1'b0;
    prog = 1'b1;
    #3;
    n_cmp++;
    if (iw_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", iw_valid); end
    @(negedge clk);
    n_cmp++;
    if ({pc, prog_empty} !== {5'd0, 1'b1} || instr_word !== img[0]) begin
      n_bad++; $display("FAIL abort_state: got pc=%0d e=%b iw=%h want 0/1/%h", pc, prog_empty, instr_word, img[0]);
    end
    prog = 1'b0;
    @(negedge clk);
    load_prog(2, -1);
    sb.push_back('{img[0], 1'b0});
    do_fetch();
    ptr_req = 1'b1;
    @(negedge clk);
    ptr_req = 1'b0;
    #3;
    n_cmp++;
    if (iw_valid !== 1'b1 || pc !== 5'd1) begin n_bad++; $display("FAIL rst_pre: got v=%b pc=%0d want 1/1", iw_valid, pc); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({iw_valid, pc, prog_empty} !== {1'b0, 5'd0, 1'b1} || instr_word !== 22'd0) begin
      n_bad++; $display("FAIL rst_mid_resp: got v=%b pc=%0d e=%b iw=%h want 0/0/1/0", iw_valid, pc, prog_empty, instr_word);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_three_words();
    test_five_words();
    test_overflow();
    test_empty_prog();
    test_back_to_back();
    test_abort_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
